// File: rtl/timing_counter.sv
// -----------------------------------------------------------------------------
// timing_counter
//
// Purpose:
//    Programmable modulo counter used as the building block of the VGA
//    horizontal (pixel) and vertical (line) timing chains. It counts up or
//    down over 0..limit. It provides clear, load and enable controls. A
//    combinational terminal-count output lets one counter enable the next.
//    NUM_CMP window comparators produce registered flags that stay aligned
//    with the count, for sync, blanking and active-video decode.
//
// Parameters:
//    BIT_WIDTH  width of count, limit, load and window values
//    NUM_CMP    number of independent window comparators
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    en         count enable; one step per cycle while high
//    clr        synchronous clear to 0 (highest priority)
//    load       synchronous load of load_val
//    load_val   value loaded when load is high
//    dir        1 = count up, 0 = count down
//    limit      terminal value; count range is 0..limit
//    win_start  per-channel window start, channel i at [i*BIT_WIDTH +: BIT_WIDTH]
//    win_end    per-channel window end (inclusive), packed the same way
//    q          current count
//    tc         terminal count (combinational), for cascading
//    wrap       registered one-cycle pulse after an enabled wrap
//    in_win     registered per-channel window flags, aligned with q
// -----------------------------------------------------------------------------
module timing_counter #(
   parameter int BIT_WIDTH = 10,
   parameter int NUM_CMP   = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           en,
   input  logic                           clr,
   input  logic                           load,
   input  logic [BIT_WIDTH-1:0]           load_val,
   input  logic                           dir,
   input  logic [BIT_WIDTH-1:0]           limit,
   input  logic [NUM_CMP*BIT_WIDTH-1:0]   win_start,
   input  logic [NUM_CMP*BIT_WIDTH-1:0]   win_end,
   output logic [BIT_WIDTH-1:0]           q,
   output logic                           tc,
   output logic                           wrap,
   output logic [NUM_CMP-1:0]             in_win
);

   logic [BIT_WIDTH-1:0] r_q;
   logic                 r_wrap;
   logic [NUM_CMP-1:0]   r_in_win;

   logic [BIT_WIDTH-1:0] w_q_next;
   logic                 w_tc;
   logic                 w_wrap_next;
   logic [NUM_CMP-1:0]   w_in_win_next;

   // Terminal count uses the live en, dir and limit. A downstream counter
   // can therefore take this as its enable with no extra cycle of delay.
   assign w_tc = en & (dir ? (r_q >= limit) : (r_q == '0));

   // Next-count selection. The >= test makes a count that was loaded above
   // limit return to 0 on the next up step instead of running past limit.
   always_comb begin
      w_q_next = r_q;
      if (clr) begin
         w_q_next = '0;
      end else if (load) begin
         w_q_next = load_val;
      end else if (en) begin
         if (dir) begin
            w_q_next = (r_q >= limit) ? '0 : r_q + 1'b1;
         end else begin
            w_q_next = (r_q == '0) ? limit : r_q - 1'b1;
         end
      end
   end

   // An enabled wrap occurs only when clr and load do not override the step.
   assign w_wrap_next = w_tc & ~clr & ~load;

   // The comparators evaluate the next count. The registered flag therefore
   // changes on the same edge as q.
   generate
      for (genvar gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
         logic [BIT_WIDTH-1:0] w_start;
         logic [BIT_WIDTH-1:0] w_end;

         assign w_start = win_start[gi*BIT_WIDTH +: BIT_WIDTH];
         assign w_end   = win_end[gi*BIT_WIDTH +: BIT_WIDTH];

         // When start > end, the window straddles the wrap point of the count.
         assign w_in_win_next[gi] = (w_start <= w_end)
                                  ? ((w_q_next >= w_start) && (w_q_next <= w_end))
                                  : ((w_q_next >= w_start) || (w_q_next <= w_end));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q      <= '0;
         r_wrap   <= 1'b0;
         r_in_win <= '0;
      end else begin
         r_q      <= w_q_next;
         r_wrap   <= w_wrap_next;
         r_in_win <= w_in_win_next;
      end
   end

   assign q      = r_q;
   assign tc     = w_tc;
   assign wrap   = r_wrap;
   assign in_win = r_in_win;

endmodule

// File: tb/tb_timing_counter.sv
// -----------------------------------------------------------------------------
// tb_timing_counter
//
// Purpose:
//    Self-checking bench for timing_counter. It instantiates a pixel counter
//    (dut) and a line counter (u_line). The line counter's enable is the
//    pixel counter's tc. A behavioural model follows both counters.
//    A negedge process compares every output against the model on each
//    cycle. Directed steps also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_timing_counter;

   localparam int BW = 10;
   localparam int NC = 2;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b1;
   logic           en       = 1'b0;
   logic           clr      = 1'b0;
   logic           load     = 1'b0;
   logic [BW-1:0]  load_val = '0;
   logic           dir      = 1'b1;
   logic [BW-1:0]  limit    = 10'd799;
   // channel 0 = 656..751, channel 1 = 700..10 (wrapped)
   logic [NC*BW-1:0] win_start = {10'd700, 10'd656};
   logic [NC*BW-1:0] win_end   = {10'd10,  10'd751};

   logic [BW-1:0]  q;
   logic           tc;
   logic           wrap;
   logic [NC-1:0]  in_win;

   // line counter: enable comes from the pixel tc
   logic           l_clr      = 1'b0;
   logic           l_load     = 1'b0;
   logic [BW-1:0]  l_load_val = '0;
   logic           l_dir      = 1'b1;
   logic [BW-1:0]  l_limit    = 10'd2;
   logic [NC*BW-1:0] l_win_start = {10'd2, 10'd1};
   logic [NC*BW-1:0] l_win_end   = {10'd0, 10'd1};
   logic [BW-1:0]  lq;
   logic           ltc;
   logic           lwrap;
   logic [NC-1:0]  l_in_win;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   timing_counter #(.BIT_WIDTH(BW), .NUM_CMP(NC)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .dir(dir), .limit(limit),
      .win_start(win_start), .win_end(win_end),
      .q(q), .tc(tc), .wrap(wrap), .in_win(in_win)
   );

   timing_counter #(.BIT_WIDTH(BW), .NUM_CMP(NC)) u_line (
      .clk(clk), .rst_n(rst_n), .en(tc), .clr(l_clr), .load(l_load),
      .load_val(l_load_val), .dir(l_dir), .limit(l_limit),
      .win_start(l_win_start), .win_end(l_win_end),
      .q(lq), .tc(ltc), .wrap(lwrap), .in_win(l_in_win)
   );

   // ---------------------------------------------------------------- model
   function automatic logic [BW-1:0] next_val(input logic [BW-1:0] cur,
                                               input logic c, input logic ld,
                                               input logic [BW-1:0] lv,
                                               input logic e, input logic d,
                                               input logic [BW-1:0] lim);
      int v;
      if (c)  return '0;
      if (ld) return lv;
      if (!e) return cur;
      if (d) begin
         if (int'(cur) >= int'(lim)) return '0;
         v = int'(cur) + 1;
      end else begin
         if (cur == '0) return lim;
         v = int'(cur) - 1;
      end
      return v[BW-1:0];
   endfunction

   function automatic logic model_tc(input logic [BW-1:0] cur, input logic e,
                                     input logic d, input logic [BW-1:0] lim);
      return e && (d ? (int'(cur) >= int'(lim)) : (cur == '0));
   endfunction

   function automatic logic [NC-1:0] members(input logic [BW-1:0] v,
                                             input logic [NC*BW-1:0] s_all,
                                             input logic [NC*BW-1:0] e_all);
      logic [NC-1:0] r;
      int s, e;
      for (int i = 0; i < NC; i++) begin
         s = int'(s_all[i*BW +: BW]);
         e = int'(e_all[i*BW +: BW]);
         if (s <= e) r[i] = (int'(v) >= s) && (int'(v) <= e);
         else        r[i] = (int'(v) >= s) || (int'(v) <= e);
      end
      return r;
   endfunction

   logic [BW-1:0] m_q  = '0;
   logic          m_wrap = 1'b0;
   logic [NC-1:0] m_win  = '0;
   logic [BW-1:0] m_lq   = '0;
   logic          m_lwrap = 1'b0;
   logic [NC-1:0] m_lwin  = '0;

   always @(posedge clk or negedge rst_n) begin : model
      logic [BW-1:0] nq, nlq;
      logic          ptc, ltc_m;
      if (!rst_n) begin
         m_q <= '0; m_wrap <= 1'b0; m_win <= '0;
         m_lq <= '0; m_lwrap <= 1'b0; m_lwin <= '0;
      end else begin
         ptc   = model_tc(m_q, en, dir, limit);
         ltc_m = model_tc(m_lq, ptc, l_dir, l_limit);
         nq    = next_val(m_q, clr, load, load_val, en, dir, limit);
         nlq   = next_val(m_lq, l_clr, l_load, l_load_val, ptc, l_dir, l_limit);
         m_q     <= nq;
         m_wrap  <= ptc && !clr && !load;
         m_win   <= members(nq, win_start, win_end);
         m_lq    <= nlq;
         m_lwrap <= ltc_m && !l_clr && !l_load;
         m_lwin  <= members(nlq, l_win_start, l_win_end);
      end
   end

   // ---------------------------------------------------------------- checks
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic lit(input string nm, input int act, input int exp);
      chk(nm, act, exp);
      $display("check %-14s q=%0d lq=%0d value=%0d want=%0d", nm, q, lq, act, exp);
   endtask

   always @(negedge clk) begin
      chk("q",        int'(q),        int'(m_q));
      chk("tc",       int'(tc),       int'(model_tc(m_q, en, dir, limit)));
      chk("wrap",     int'(wrap),     int'(m_wrap));
      chk("in_win",   int'(in_win),   int'(m_win));
      chk("line_q",   int'(lq),       int'(m_lq));
      chk("line_wrap",int'(lwrap),    int'(m_lwrap));
      chk("line_win", int'(l_in_win), int'(m_lwin));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      // reset state and tc equation while held in reset
      #1 rst_n = 1'b0;
      #1;
      lit("rst_q", int'(q), 0);
      lit("rst_wrap", int'(wrap), 0);
      lit("rst_in_win", int'(in_win), 0);
      en = 1'b1; dir = 1'b0; #1;
      lit("rst_tc_down", int'(tc), 1);
      dir = 1'b1; limit = 10'd0; #1;
      lit("rst_tc_lim0", int'(tc), 1);
      limit = 10'd799; #1;
      lit("rst_tc_up", int'(tc), 0);
      en = 1'b0;
      step();
      rst_n = 1'b1; en = 1'b1; dir = 1'b1;
      #1 lit("pre_in_win", int'(in_win), 0);

      // up count with wrap and window flags
      for (int k = 1; k <= 801; k++) begin
         step();
         if (k == 1)   begin lit("up_q1", int'(q), 1); lit("up_win1", int'(in_win), 2); end
         if (k == 655) lit("win_655", int'(in_win), 0);
         if (k == 656) lit("win_656", int'(in_win), 1);
         if (k == 700) lit("win_700", int'(in_win), 3);
         if (k == 751) lit("win_751", int'(in_win), 3);
         if (k == 752) lit("win_752", int'(in_win), 2);
         if (k == 798) lit("tc_798", int'(tc), 0);
         if (k == 799) begin
            lit("up_q799", int'(q), 799); lit("tc_799", int'(tc), 1);
            lit("wrap_799", int'(wrap), 0);
         end
         if (k == 800) begin
            lit("up_wrapq", int'(q), 0); lit("wrap_pulse", int'(wrap), 1);
            lit("win_0", int'(in_win), 2);
         end
         if (k == 801) lit("wrap_clear", int'(wrap), 0);
      end

      // priority: clr > load > en
      clr = 1'b1; load = 1'b1; load_val = 10'd300; step();
      lit("prio_clr", int'(q), 0); lit("prio_wrap", int'(wrap), 0);
      clr = 1'b0; step();
      lit("prio_load", int'(q), 300);
      load_val = 10'd900; step();
      lit("load_over", int'(q), 900);
      load = 1'b0; #1 lit("tc_over", int'(tc), 1);
      step();
      lit("over_wrap_q", int'(q), 0); lit("over_wrap", int'(wrap), 1);
      load_val = 10'd799; load = 1'b1; step();
      load = 1'b0; clr = 1'b1; #1 lit("tc_vs_clr", int'(tc), 1);
      step();
      lit("clr_tc_q", int'(q), 0); lit("clr_tc_wrap", int'(wrap), 0);
      clr = 1'b0;

      // down count
      dir = 1'b0; limit = 10'd524; load_val = 10'd2; load = 1'b1; step();
      lit("dn_load", int'(q), 2);
      load = 1'b0; step(); lit("dn_1", int'(q), 1);
      step(); lit("dn_0", int'(q), 0); lit("dn_tc", int'(tc), 1);
      step(); lit("dn_524", int'(q), 524); lit("dn_wrap", int'(wrap), 1);
      step(); lit("dn_523", int'(q), 523); lit("dn_wrap_clr", int'(wrap), 0);

      // limit = 0 counting up: stuck at 0, continuous wrap
      dir = 1'b1; limit = 10'd0; clr = 1'b1; step(); clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         lit("lim0_q", int'(q), 0); lit("lim0_wrap", int'(wrap), 1);
         lit("lim0_tc", int'(tc), 1);
      end

      // cascade: pixel limit 3 drives line counter with limit 2
      limit = 10'd3; clr = 1'b1; l_clr = 1'b1; step();
      clr = 1'b0; l_clr = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 3)  lit("cas_3", int'(lq), 0);
         if (k == 4)  begin lit("cas_4", int'(lq), 1); lit("cas_4w", int'(lwrap), 0); end
         if (k == 8)  lit("cas_8", int'(lq), 2);
         if (k == 11) lit("cas_11", int'(lq), 2);
         if (k == 12) begin lit("cas_12", int'(lq), 0); lit("cas_12w", int'(lwrap), 1); end
      end

      // asynchronous reset mid-count
      limit = 10'd799; win_start[BW-1:0] = 10'd400;
      load_val = 10'd416; load = 1'b1; step();
      load = 1'b0; step();
      lit("ar_q417", int'(q), 417); lit("ar_win", int'(in_win), 1);
      #2 rst_n = 1'b0;
      #1;
      lit("ar_q", int'(q), 0); lit("ar_wrap", int'(wrap), 0);
      lit("ar_in_win", int'(in_win), 0);
      step(); step();
      rst_n = 1'b1;
      #1 lit("ar_rel_q", int'(q), 0);
      step();
      lit("ar_resume", int'(q), 1); lit("ar_resume_win", int'(in_win), 2);

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
